// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - raster timing types, 640x480@60 defaults and total helper
package vga_timing_pkg;

    localparam int unsigned DEF_PIX_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    function automatic int unsigned timing_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - clock-enable divider producing a one-cycle strobe every PIX_DIV cycles
//   CLK_40  in  system clock
//   reset_n in  asynchronous active-low reset
//   run     in  1 = count, 0 = count held at 0 and strobe suppressed
//   pix_en  out registered strobe, high one cycle in PIX_DIV
module clk_en_div #(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic CLK_40,
    input  logic reset_n,
    input  logic run,
    output logic pix_en
);

    // A one-state divider still needs a 1-bit counter to keep the types legal.
    localparam int unsigned CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            pix_en <= 1'b0;
        end else if (!run) begin
            count  <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= (count == CNT_LAST);
            count  <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing: pixel enable, x/y counters, syncs, de, strobes
//   CLK_40      in  system clock
//   reset_n     in  asynchronous active-low reset
//   run         in  1 = raster advances, 0 = freeze with outputs inactive
//   pix_en      out one-cycle pixel clock-enable
//   x_pos/y_pos out current column / line
//   hsync/vsync out sync pulses, asserted level set by *_SYNC_POL
//   de          out current position is visible
//   line_start  out pulse when x_pos becomes 0
//   frame_start out pulse when (x_pos,y_pos) becomes (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV    = DEF_PIX_DIV,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL   = timing_total(timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP}),
    localparam int unsigned V_TOTAL   = timing_total(timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP}),
    localparam int unsigned X_W       = $clog2(H_TOTAL),
    localparam int unsigned Y_W       = $clog2(V_TOTAL)
) (
    input  logic           CLK_40,
    input  logic           reset_n,
    input  logic           run,
    output logic           pix_en,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           line_start,
    output logic           frame_start
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    // Window bounds carry one extra bit so an end bound equal to the total
    // still compares correctly even when the total is a power of two.
    localparam logic [X_W:0] X_DE_HI = (X_W + 1)'(H_ACTIVE);
    localparam logic [X_W:0] X_HS_LO = (X_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [X_W:0] X_HS_HI = (X_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W:0] Y_DE_HI = (Y_W + 1)'(V_ACTIVE);
    localparam logic [Y_W:0] Y_VS_LO = (Y_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [Y_W:0] Y_VS_HI = (Y_W + 1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;
    logic           hs_win;
    logic           vs_win;
    logic           de_win;
    logic           wrap_x;

    clk_en_div #(
        .PIX_DIV (PIX_DIV)
    ) u_clk_en_div (
        .CLK_40  (CLK_40),
        .reset_n (reset_n),
        .run     (run),
        .pix_en  (pix_en)
    );

    // Next raster position; y only moves on the x wrap.
    always_comb begin
        x_nxt  = x_pos;
        y_nxt  = y_pos;
        wrap_x = (x_pos == X_LAST);
        if (pix_en) begin
            if (wrap_x) begin
                x_nxt = '0;
                y_nxt = (y_pos == Y_LAST) ? '0 : y_pos + Y_W'(1);
            end else begin
                x_nxt = x_pos + X_W'(1);
            end
        end
    end

    // Decode from the next position so registered syncs/de line up with the
    // registered x_pos/y_pos they describe.
    always_comb begin
        hs_win = ({1'b0, x_nxt} >= X_HS_LO) && ({1'b0, x_nxt} < X_HS_HI);
        vs_win = ({1'b0, y_nxt} >= Y_VS_LO) && ({1'b0, y_nxt} < Y_VS_HI);
        de_win = ({1'b0, x_nxt} < X_DE_HI) && ({1'b0, y_nxt} < Y_DE_HI);
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            x_pos       <= X_LAST;
            y_pos       <= Y_LAST;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run) begin
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x_pos       <= x_nxt;
            y_pos       <= y_nxt;
            hsync       <= hs_win ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_win ? V_SYNC_POL : ~V_SYNC_POL;
            de          <= de_win;
            line_start  <= pix_en && (x_nxt == '0);
            frame_start <= pix_en && (x_nxt == '0) && (y_nxt == '0);
        end
    end

endmodule
